// File: rtl/parking_pkg.sv
// Shared state encoding and helpers for the parking entrance-gate controller.
package parking_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        WAIT_PASS = 3'd1,
        GRANTED   = 3'd2,
        DENIED    = 3'd3,
        STOP      = 3'd4,
        LOCKED    = 3'd5
    } state_e;

    // States in which a visit is abandoned if the driver takes too long.
    function automatic logic is_timed(input state_e s);
        return (s == WAIT_PASS) || (s == DENIED) || (s == STOP);
    endfunction

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// Sensor/keypad inputs and gate/LED outputs of the entrance-gate controller.
interface parking_gate_ctrl_if #(
    parameter int PASS_W = 8,
    parameter int OCC_W  = 5
);
    logic              sensor_entrance;
    logic              sensor_exit;
    logic              car_leave;
    logic              pass_valid;
    logic [PASS_W-1:0] pass_data;
    logic              green_led;
    logic              red_led;
    logic              gate_open;
    logic              full;
    logic              locked;
    logic [OCC_W-1:0]  occupancy;

    modport master (
        output sensor_entrance, sensor_exit, car_leave, pass_valid, pass_data,
        input  green_led, red_led, gate_open, full, locked, occupancy
    );

    modport slave (
        input  sensor_entrance, sensor_exit, car_leave, pass_valid, pass_data,
        output green_led, red_led, gate_open, full, locked, occupancy
    );
endinterface

// File: rtl/parking_occ_counter.sv
// Saturating up/down occupancy counter; simultaneous inc and dec cancel out.
module parking_occ_counter #(
    parameter  int CAPACITY = 16,
    localparam int CNT_W    = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             at_cap;
    logic             at_zero;

    assign at_cap  = (count_q == CNT_W'(CAPACITY));
    assign at_zero = (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (inc && !dec && !at_cap) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec && !inc && !at_zero) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign full  = at_cap;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entrance-gate controller: password entry, occupancy tracking, per-visit timeout.
// Define PARKING_LOCKOUT_EN to add the LOCKED state after MAX_TRIES wrong passwords.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int                PASS_W      = 8,
    parameter logic [PASS_W-1:0] GARAGE_PASS = PASS_W'(8'h0F),
    parameter int                CAPACITY    = 16,
    parameter int                TIMEOUT_CYC = 255,
    parameter int                MAX_TRIES   = 3,
    parameter int                LOCK_CYC    = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    parking_gate_ctrl_if.slave   bus
);

    localparam int OCC_W = $clog2(CAPACITY + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYC);

    state_e           state_q;
    state_e           state_d;
    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;
    logic [OCC_W-1:0] occ;
    logic             occ_full;
    logic             occ_inc;
    logic             match;
    logic             miss;
    logic             timeout;
    logic             room_after;
    logic             lock_hit;

    assign match      = bus.pass_valid && (bus.pass_data == GARAGE_PASS);
    assign miss       = bus.pass_valid && !match;
    assign timeout    = (timer_q == TMR_W'(TIMEOUT_CYC - 1)) && !bus.pass_valid;
    assign occ_inc    = (state_q == GRANTED) && bus.sensor_exit;
    assign room_after = (int'(occ) + 1) < CAPACITY;

    parking_occ_counter #(
        .CAPACITY (CAPACITY)
    ) u_occ (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (occ_inc),
        .dec   (bus.car_leave),
        .count (occ),
        .full  (occ_full)
    );

`ifdef PARKING_LOCKOUT_EN
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int LCK_W = $clog2(LOCK_CYC + 1);

    logic [TRY_W-1:0] tries_q;
    logic [TRY_W-1:0] tries_d;
    logic [LCK_W-1:0] lock_q;
    logic [LCK_W-1:0] lock_d;
    logic             lock_done;

    assign lock_hit  = miss && (tries_q == TRY_W'(MAX_TRIES - 1));
    assign lock_done = (lock_q == LCK_W'(LOCK_CYC - 1));

    // Tries accumulate across a whole visit (including tailgate retries) and clear once back in IDLE.
    always_comb begin
        tries_d = tries_q;
        lock_d  = '0;
        if ((state_q == IDLE) || (state_d == IDLE)) begin
            tries_d = '0;
        end else if (miss && is_timed(state_q)) begin
            tries_d = tries_q + TRY_W'(1);
        end
        if ((state_q == LOCKED) && (state_d == LOCKED)) begin
            lock_d = lock_q + LCK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tries_q <= '0;
            lock_q  <= '0;
        end else begin
            tries_q <= tries_d;
            lock_q  <= lock_d;
        end
    end
`else
    assign lock_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.sensor_entrance && !occ_full) begin
                    state_d = WAIT_PASS;
                end
            end
            WAIT_PASS, DENIED, STOP: begin
                if (match) begin
                    state_d = GRANTED;
                end else if (miss) begin
                    if (lock_hit) begin
                        state_d = LOCKED;
                    end else if (state_q == WAIT_PASS) begin
                        state_d = DENIED;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            GRANTED: begin
                if (bus.sensor_exit) begin
                    state_d = (bus.sensor_entrance && room_after) ? STOP : IDLE;
                end
            end
`ifdef PARKING_LOCKOUT_EN
            LOCKED: begin
                if (lock_done) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Timer holds at its last value so a wrong password on the final cycle still leaves a timeout pending.
    always_comb begin
        timer_d = '0;
        if ((state_d == state_q) && is_timed(state_q)) begin
            timer_d = (timer_q == TMR_W'(TIMEOUT_CYC - 1)) ? timer_q : timer_q + TMR_W'(1);
        end
    end

    always_comb begin
        bus.green_led = (state_q == GRANTED);
        bus.gate_open = (state_q == GRANTED);
`ifdef PARKING_LOCKOUT_EN
        bus.red_led   = (state_q == DENIED) || (state_q == LOCKED);
        bus.locked    = (state_q == LOCKED);
`else
        bus.red_led   = (state_q == DENIED);
        bus.locked    = 1'b0;
`endif
    end

    assign bus.full      = occ_full;
    assign bus.occupancy = occ;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: vector table, corner sequences, randomized run vs reference model.
module tb_parking_gate_ctrl;

    localparam int CAP       = 2;
    localparam int TMO       = 255;
    localparam int MAX_TRIES = 3;
    localparam int LOCK_CYC  = 1024;
    localparam int OCC_W     = $clog2(CAP + 1);
`ifdef PARKING_LOCKOUT_EN
    localparam bit LOCKOUT   = 1'b1;
`else
    localparam bit LOCKOUT   = 1'b0;
`endif

    localparam int MD_IDLE = 0;
    localparam int MD_WAIT = 1;
    localparam int MD_OPEN = 2;
    localparam int MD_DENY = 3;
    localparam int MD_TAIL = 4;
    localparam int MD_LOCK = 5;

    typedef struct {
        logic       ent;
        logic       ex;
        logic       lv;
        logic       pv;
        logic [7:0] pd;
        logic [6:0] exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    int m_mode, m_occ, m_timer, m_tries, m_lock;

    always #5 clk = ~clk;

    parking_gate_ctrl_if #(.PASS_W(8), .OCC_W(OCC_W)) bus ();

    parking_gate_ctrl #(
        .PASS_W      (8),
        .GARAGE_PASS (8'h0F),
        .CAPACITY    (CAP),
        .TIMEOUT_CYC (TMO),
        .MAX_TRIES   (MAX_TRIES),
        .LOCK_CYC    (LOCK_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Output vector layout: {green, red, gate, full, locked, occupancy[1:0]}
    function automatic logic [6:0] exp_o(input logic g, input logic r, input logic f,
                                         input logic l, input int occ);
        return {g, r, g, f, l, 2'(occ)};
    endfunction

    function automatic logic [6:0] dut_out();
        return {bus.green_led, bus.red_led, bus.gate_open, bus.full, bus.locked, bus.occupancy};
    endfunction

    function automatic logic [6:0] model_out();
        return exp_o(m_mode == MD_OPEN, (m_mode == MD_DENY) || (m_mode == MD_LOCK),
                     m_occ == CAP, m_mode == MD_LOCK, m_occ);
    endfunction

    function automatic void model_reset();
        m_mode  = MD_IDLE;
        m_occ   = 0;
        m_timer = 0;
        m_tries = 0;
        m_lock  = 0;
    endfunction

    // Reference model: one call per rising edge, using the inputs sampled at that edge.
    function automatic void model_step(input logic ent, input logic ex, input logic lv,
                                       input logic pv, input logic [7:0] pd);
        bit hit     = pv && (pd == 8'h0F);
        bit wrong   = pv && !hit;
        bit expired = (m_timer >= TMO - 1) && !pv;
        bit timed   = (m_mode == MD_WAIT) || (m_mode == MD_DENY) || (m_mode == MD_TAIL);
        int nxt     = m_mode;
        int inc     = 0;
        case (m_mode)
            MD_IDLE: if (ent && m_occ < CAP) nxt = MD_WAIT;
            MD_WAIT, MD_DENY, MD_TAIL: begin
                if (hit) nxt = MD_OPEN;
                else if (wrong) begin
                    m_tries++;
                    if (LOCKOUT && m_tries >= MAX_TRIES) nxt = MD_LOCK;
                    else if (m_mode == MD_WAIT) nxt = MD_DENY;
                end else if (expired) nxt = MD_IDLE;
            end
            MD_OPEN: if (ex) begin
                inc = 1;
                nxt = (ent && (m_occ + 1 < CAP)) ? MD_TAIL : MD_IDLE;
            end
            MD_LOCK: if (m_lock + 1 >= LOCK_CYC) nxt = MD_IDLE;
            default: nxt = MD_IDLE;
        endcase
        m_occ = m_occ + inc - (lv ? 1 : 0);
        if (m_occ > CAP) m_occ = CAP;
        if (m_occ < 0) m_occ = 0;
        m_timer = (nxt == m_mode && timed) ? m_timer + 1 : 0;
        m_lock  = (nxt == MD_LOCK && m_mode == MD_LOCK) ? m_lock + 1 : 0;
        if (nxt == MD_IDLE || m_mode == MD_IDLE) m_tries = 0;
        m_mode = nxt;
    endfunction

    task automatic check_vec(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %b expected %b (g r gate full lock occ)", name, act, exp);
        end
    endtask

    task automatic check_output(input string name);
        check_vec(name, dut_out(), model_out());
    endtask

    // Called at a falling edge: drive, let the rising edge happen, compare at the next falling edge.
    task automatic apply_stimulus(input logic ent, input logic ex, input logic lv,
                                  input logic pv, input logic [7:0] pd, input string name);
        bus.sensor_entrance = ent;
        bus.sensor_exit     = ex;
        bus.car_leave       = lv;
        bus.pass_valid      = pv;
        bus.pass_data       = pd;
        @(posedge clk);
        model_step(ent, ex, lv, pv, pd);
        @(negedge clk);
        check_output(name);
    endtask

    task automatic idle_cycles(input int n, input string name);
        for (int k = 0; k < n; k++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, name);
    endtask

    task automatic do_reset();
        bus.sensor_entrance = 1'b0;
        bus.sensor_exit     = 1'b0;
        bus.car_leave       = 1'b0;
        bus.pass_valid      = 1'b0;
        bus.pass_data       = 8'h00;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_output("reset_async");
        check_vec("reset_const", dut_out(), 7'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t vecs[17];
        int   lock_cycles;
        logic r_ent, r_ex, r_lv, r_pv;
        logic [7:0] r_pd;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, exp_o(0, 0, 0, 0, 0)};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h0F, exp_o(1, 0, 0, 0, 0)};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, exp_o(0, 0, 0, 0, 1)};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, exp_o(0, 0, 0, 0, 1)};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h05, exp_o(0, 1, 0, 0, 1)};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h0F, exp_o(1, 0, 0, 0, 1)};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, exp_o(0, 0, 1, 0, 2)};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, exp_o(0, 0, 1, 0, 2)};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h0F, exp_o(0, 0, 1, 0, 2)};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, exp_o(0, 0, 0, 0, 1)};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, exp_o(0, 0, 0, 0, 0)};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, exp_o(0, 0, 0, 0, 0)};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, exp_o(0, 0, 0, 0, 0)};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h0F, exp_o(1, 0, 0, 0, 0)};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, exp_o(0, 0, 0, 0, 1)};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h0F, exp_o(1, 0, 0, 0, 1)};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, exp_o(0, 0, 0, 0, 1)};

        bus.sensor_entrance = 1'b0;
        bus.sensor_exit     = 1'b0;
        bus.car_leave       = 1'b0;
        bus.pass_valid      = 1'b0;
        bus.pass_data       = 8'h00;
        model_reset();
        #1;
        check_vec("reset_initial", dut_out(), 7'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            apply_stimulus(vecs[i].ent, vecs[i].ex, vecs[i].lv, vecs[i].pv, vecs[i].pd,
                           $sformatf("vec%0d_model", i));
            check_vec($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
        end

        // Password on the last allowed cycle is still accepted.
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "tmo_a_enter");
        idle_cycles(TMO - 1, "tmo_a_wait");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h0F, "tmo_a_pass_model");
        check_vec("tmo_last_cycle_accept", dut_out(), exp_o(1, 0, 0, 0, 1));
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "tmo_a_exit");
        check_vec("tmo_a_exit_full", dut_out(), exp_o(0, 0, 1, 0, 2));
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "tmo_a_leave");

        // One cycle more and the visit is abandoned; the late password is ignored.
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "tmo_b_enter");
        idle_cycles(TMO, "tmo_b_wait");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h0F, "tmo_b_pass_model");
        check_vec("tmo_expired_ignore", dut_out(), exp_o(0, 0, 0, 0, 1));

        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "miss_enter");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h05, "miss1");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'hF0, "miss2");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h0E, "miss3_model");
`ifdef PARKING_LOCKOUT_EN
        check_vec("lock_after_3_miss", dut_out(), exp_o(0, 1, 0, 1, 1));
        lock_cycles = 1;
        for (int k = 0; k < LOCK_CYC; k++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h0F, "lock_hold");
            if (bus.locked) lock_cycles++;
        end
        n_checks++;
        if (lock_cycles != LOCK_CYC) begin
            n_errors++;
            $display("[TB] FAIL lock_duration: got %0d cycles expected %0d", lock_cycles, LOCK_CYC);
        end
        check_vec("lock_released_idle", dut_out(), exp_o(0, 0, 0, 0, 1));
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "post_lock_enter");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h05, "post_lock_miss1");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h05, "post_lock_miss2");
        check_vec("tries_cleared", dut_out(), exp_o(0, 1, 0, 0, 1));
        idle_cycles(TMO, "post_lock_timeout");
`else
        check_vec("no_lock_3_miss", dut_out(), exp_o(0, 1, 0, 0, 1));
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h33, "miss4");
        check_vec("no_lock_4_miss", dut_out(), exp_o(0, 1, 0, 0, 1));
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h0F, "miss_then_pass_model");
        check_vec("miss_then_pass", dut_out(), exp_o(1, 0, 0, 0, 1));
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "miss_exit");
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "miss_leave");
`endif

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            r_ent = 1'($urandom_range(0, 1));
            r_ex  = ($urandom_range(0, 9) < 3);
            r_lv  = ($urandom_range(0, 9) < 1);
            r_pv  = ($urandom_range(0, 3) == 0);
            r_pd  = ($urandom_range(0, 1) == 0) ? 8'h0F : 8'($urandom_range(0, 255));
            apply_stimulus(r_ent, r_ex, r_lv, r_pv, r_pd, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
